run_checker: RTL and testbench

RUN_CHECKER -- requirements
Module: run_checker

---
 rtl/run_checker.sv | 175 +++++++++++++++++
 tb/tb_run_checker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/run_checker.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | run_checker: lets a CPU run until its PC halts or a step limit expires, |
// | then compares the data RAM word-by-word against an expected image.     |
// | Optional: RUN_CHECKER_FIRST_ERR_EN adds first-mismatch capture.        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module run_checker #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int DEPTH       = 1024,
    parameter int HALT_CYCLES = 2,
    parameter int MAX_STEPS   = 1000,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  pc_stall,
    output logic [ADDR_WIDTH-1:0] m_r_addr,
    output logic                  m_r_enb,
    input  logic [DATA_WIDTH-1:0] m_r_dat,
    output logic [ADDR_WIDTH-1:0] e_r_addr,
    output logic                  e_r_enb,
    input  logic [DATA_WIDTH-1:0] e_r_dat,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_got,
    output logic [DATA_WIDTH-1:0] first_err_exp
);

    localparam int c_step_w = $clog2(MAX_STEPS + 1);
    localparam int c_stab_w = $clog2(HALT_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] c_last_idx  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [c_step_w-1:0]   c_last_step = c_step_w'(MAX_STEPS - 1);
    localparam logic [c_stab_w-1:0]   c_halt_cnt  = c_stab_w'(HALT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_SCAN  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  r_state;
    logic [c_step_w-1:0]     r_step_cnt;
    logic [c_stab_w-1:0]     r_stable_cnt;
    logic [DATA_WIDTH-1:0]   r_pc_q;
    logic                    r_cmp_vld;

    logic                    w_pc_same;
    logic                    w_halt;
    logic                    w_limit;
    logic                    w_mismatch;
    logic                    w_start_go;
    logic [CNT_WIDTH-1:0]    w_err_next;

    assign w_pc_same  = (pc == r_pc_q);
    assign w_halt     = w_pc_same && (r_stable_cnt == c_halt_cnt);
    assign w_limit    = (r_step_cnt == c_last_step);
    // Read data lags the issued index by one cycle, so compare on the delayed valid.
    assign w_mismatch = r_cmp_vld && (m_r_dat != e_r_dat);
    assign w_start_go = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_err_next = (w_mismatch && !(&err_count)) ? err_count + 1'b1 : err_count;

    assign e_r_addr = m_r_addr;
    assign e_r_enb  = m_r_enb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            pc_stall     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            err_count    <= '0;
            m_r_addr     <= '0;
            m_r_enb      <= 1'b0;
            r_step_cnt   <= '0;
            r_stable_cnt <= '0;
            r_pc_q       <= '0;
            r_cmp_vld    <= 1'b0;
        end else begin
            r_cmp_vld <= 1'b0;
            err_count <= w_err_next;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_go) begin
                        r_state      <= S_RUN;
                        pc_stall     <= 1'b0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        timeout      <= 1'b0;
                        err_count    <= '0;
                        r_step_cnt   <= '0;
                        r_stable_cnt <= '0;
                        r_pc_q       <= '1;
                    end
                end
                S_RUN: begin
                    r_step_cnt   <= r_step_cnt + 1'b1;
                    r_pc_q       <= pc;
                    r_stable_cnt <= w_pc_same ? r_stable_cnt + 1'b1 : '0;
                    // Halt takes precedence when it lands on the final allowed step.
                    if (w_halt || w_limit) begin
                        r_state  <= S_SCAN;
                        pc_stall <= 1'b1;
                        timeout  <= !w_halt;
                        m_r_enb  <= 1'b1;
                        m_r_addr <= '0;
                    end
                end
                S_SCAN: begin
                    r_cmp_vld <= 1'b1;
                    if (m_r_addr == c_last_idx) begin
                        r_state  <= S_DRAIN;
                        m_r_enb  <= 1'b0;
                        m_r_addr <= '0;
                    end else begin
                        m_r_addr <= m_r_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    pass    <= !timeout && (w_err_next == '0);
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RUN_CHECKER_FIRST_ERR_EN
    logic [ADDR_WIDTH-1:0] r_cmp_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_addr <= '0;
        end else begin
            r_cmp_addr <= m_r_addr;
        end
    end

    // A zero error count means no earlier mismatch; saturation never returns it to zero.
    always_ff @(posedge clk) begin
        if (rst || w_start_go) begin
            first_err_addr <= '0;
            first_err_got  <= '0;
            first_err_exp  <= '0;
        end else if (w_mismatch && (err_count == '0)) begin
            first_err_addr <= r_cmp_addr;
            first_err_got  <= m_r_dat;
            first_err_exp  <= e_r_dat;
        end
    end
`else
    assign first_err_addr = '0;
    assign first_err_got  = '0;
    assign first_err_exp  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_run_checker.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_run_checker: directed bench for run_checker (DEPTH=16, HALT=2,      |
// | MAX_STEPS=40) plus a CNT_WIDTH=2 instance for counter saturation.      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_run_checker;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, start2;
    logic [DW-1:0] pc, pc2;

    logic          pc_stall, m_r_enb, e_r_enb, busy, done, pass, timeout;
    logic [AW-1:0] m_r_addr, e_r_addr, first_err_addr;
    logic [DW-1:0] m_r_dat, e_r_dat, first_err_got, first_err_exp;
    logic [15:0]   err_count;

    logic          pc_stall2, m_r_enb2, e_r_enb2, busy2, done2, pass2, timeout2;
    logic [AW-1:0] m_r_addr2, e_r_addr2, first_err_addr2;
    logic [DW-1:0] m_r_dat2, e_r_dat2, first_err_got2, first_err_exp2;
    logic [1:0]    err_count2;

    logic [DW-1:0] mem_d [DEPTH];
    logic [DW-1:0] mem_e [DEPTH];

    int tests = 0;
    int fails = 0;

    run_checker #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .HALT_CYCLES(2),
                  .MAX_STEPS(40), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .pc_stall(pc_stall),
        .m_r_addr(m_r_addr), .m_r_enb(m_r_enb), .m_r_dat(m_r_dat),
        .e_r_addr(e_r_addr), .e_r_enb(e_r_enb), .e_r_dat(e_r_dat),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
        .first_err_addr(first_err_addr), .first_err_got(first_err_got),
        .first_err_exp(first_err_exp)
    );

    run_checker #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .HALT_CYCLES(2),
                  .MAX_STEPS(40), .CNT_WIDTH(2)) u_dut_sat (
        .clk(clk), .rst(rst), .start(start2), .pc(pc2), .pc_stall(pc_stall2),
        .m_r_addr(m_r_addr2), .m_r_enb(m_r_enb2), .m_r_dat(m_r_dat2),
        .e_r_addr(e_r_addr2), .e_r_enb(e_r_enb2), .e_r_dat(e_r_dat2),
        .busy(busy2), .done(done2), .pass(pass2), .timeout(timeout2), .err_count(err_count2),
        .first_err_addr(first_err_addr2), .first_err_got(first_err_got2),
        .first_err_exp(first_err_exp2)
    );

    // Synchronous-read RAM models, one cycle of latency after enable.
    always @(posedge clk) begin
        if (m_r_enb)  m_r_dat  <= mem_d[m_r_addr[3:0]];
        if (e_r_enb)  e_r_dat  <= mem_e[e_r_addr[3:0]];
        if (m_r_enb2) m_r_dat2 <= mem_d[m_r_addr2[3:0]];
        if (e_r_enb2) e_r_dat2 <= mem_e[e_r_addr2[3:0]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_same;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = 32'h1000_0000 + i * 32'h0101;
            mem_e[i] = mem_d[i];
        end
    endtask

    // CPU model: PC advances by step (clamped at lim) after every unstalled cycle.
    task automatic do_run(input logic [31:0] step, input logic [31:0] lim, output int run_cyc);
        pc = '0;
        start = 1'b1;
        tick;
        start = 1'b0;
        run_cyc = 0;
        while (pc_stall == 1'b0 && run_cyc < 200) begin
            run_cyc++;
            tick;
            pc = (pc + step > lim) ? lim : pc + step;
        end
    endtask

    task automatic do_scan(input int start_at, output int scan_cyc, output bit seq_ok,
                           output int enb_cnt);
        scan_cyc = 0;
        seq_ok   = 1'b1;
        enb_cnt  = 0;
        while (done == 1'b0 && scan_cyc < 100) begin
            if (m_r_enb) begin
                if (m_r_addr != AW'(enb_cnt) || e_r_addr != m_r_addr || !e_r_enb) seq_ok = 1'b0;
                enb_cnt++;
            end else if (m_r_addr != '0 || e_r_addr != '0 || e_r_enb) begin
                seq_ok = 1'b0;
            end
            if (pc_stall != 1'b1 || busy != 1'b1) seq_ok = 1'b0;
            start = (scan_cyc == start_at);
            scan_cyc++;
            tick;
        end
        start = 1'b0;
    endtask

    int rc, sc, ec;
    bit ok;

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0; pc = '0; pc2 = '0;
        fill_same;
        repeat (3) tick;
        rst = 1'b0;
        tick;

        // Reset / idle state
        check("rst_flags", {pc_stall, busy, done, pass, timeout, m_r_enb, e_r_enb}, 7'b1000000);
        check("rst_err", err_count, 0);
        check("rst_addr", {m_r_addr, e_r_addr}, 0);
        check("rst_first_err", {first_err_addr, first_err_got, first_err_exp}, 0);

        // Halting program, identical RAMs
        do_run(32'h4, 32'hC, rc);
        check("t1_run_cycles", rc, 6);
        do_scan(-1, sc, ok, ec);
        check("t1_scan_to_done", sc, DEPTH + 1);
        check("t1_scan_seq", ok, 1);
        check("t1_enb_cycles", ec, DEPTH);
        check("t1_flags", {done, busy, pass, timeout, pc_stall}, 5'b10101);
        check("t1_err", err_count, 0);
        repeat (3) tick;
        check("t1_held", {done, pass, busy}, 3'b110);

        // Runaway program hits the step limit; start during scan is ignored
        do_run(32'h1, 32'hFFFF_FF00, rc);
        check("t2_run_cycles", rc, 40);
        do_scan(3, sc, ok, ec);
        check("t2_scan_to_done", sc, DEPTH + 1);
        check("t2_enb_cycles", ec, DEPTH);
        check("t2_flags", {done, pass, timeout}, 3'b101);
        check("t2_err", err_count, 0);

        // Two mismatching words
        mem_d[5] = 32'hDEAD_BEEF;
        mem_e[5] = 32'h0000_0000;
        mem_d[9] = mem_e[9] ^ 32'h0000_0010;
        do_run(32'h4, 32'hC, rc);
        check("t3_run_cycles", rc, 6);
        do_scan(-1, sc, ok, ec);
        check("t3_err", err_count, 2);
        check("t3_flags", {done, pass, timeout}, 3'b100);
        repeat (2) tick;
`ifdef RUN_CHECKER_FIRST_ERR_EN
        check("t3_fe_addr", first_err_addr, 5);
        check("t3_fe_got", first_err_got, 32'hDEAD_BEEF);
        check("t3_fe_exp", first_err_exp, 32'h0000_0000);
`else
        check("t3_fe_addr", first_err_addr, 0);
        check("t3_fe_got", first_err_got, 0);
        check("t3_fe_exp", first_err_exp, 0);
`endif

        // Halt lands exactly on step 40: halt wins over the limit
        fill_same;
        do_run(32'h1, 32'd37, rc);
        check("t4_run_cycles", rc, 40);
        do_scan(-1, sc, ok, ec);
        check("t4_flags", {done, pass, timeout}, 3'b110);
        check("t4_fe_cleared", {first_err_addr, first_err_got}, 0);
        // One step later is too late: limit reached first
        do_run(32'h1, 32'd38, rc);
        check("t4b_run_cycles", rc, 40);
        do_scan(-1, sc, ok, ec);
        check("t4b_flags", {done, pass, timeout}, 3'b101);

        // Reset in the middle of the scan
        mem_d[2] = ~mem_e[2];
        do_run(32'h4, 32'hC, rc);
        repeat (7) tick;
        check("t5_at_idx7", {m_r_enb, m_r_addr}, {1'b1, 12'd7});
        check("t5_err_before", err_count, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("t5_flags", {pc_stall, busy, done, pass, timeout, m_r_enb, e_r_enb}, 7'b1000000);
        check("t5_err", err_count, 0);
        check("t5_addr", {m_r_addr, e_r_addr}, 0);
        check("t5_first_err", {first_err_addr, first_err_got, first_err_exp}, 0);
        rst = 1'b1; start = 1'b1;
        tick;
        rst = 1'b0; start = 1'b0;
        check("t5_rst_over_start", {pc_stall, busy}, 2'b10);
        fill_same;
        do_run(32'h4, 32'hC, rc);
        check("t5_rerun_cycles", rc, 6);
        do_scan(-1, sc, ok, ec);
        check("t5_rerun_flags", {done, pass, timeout}, 3'b110);
        check("t5_rerun_err", err_count, 0);

        // Every word differs on a 2-bit counter
        for (int i = 0; i < DEPTH; i++) mem_e[i] = ~mem_d[i];
        pc2 = '0;
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        sc = 0;
        while (done2 == 1'b0 && sc < 200) begin
            sc++;
            tick;
        end
        check("t6_done", done2, 1);
        check("t6_err_sat", err_count2, 2'd3);
        check("t6_flags", {pass2, timeout2}, 2'b00);
`ifdef RUN_CHECKER_FIRST_ERR_EN
        check("t6_fe", {first_err_addr2, first_err_got2, first_err_exp2},
              {12'd0, 32'h1000_0000, 32'hEFFF_FFFF});
`else
        check("t6_fe", {first_err_addr2, first_err_got2, first_err_exp2}, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
